seq_stage_ctrl: RTL and testbench

Multi-cycle stage sequencer for the sequential Y86-64 core. It replaces the free-running testbench clock/PC loop with a controlled sequence: fetch, decode, execute, memory, writeback, PC-update. It owns the architectural PC register and the 2-bit stat code, stalls on a data-memory ready handshake, and exposes retired-instruction and cycle counters. It sits at the core top between the bench/clock source and the stage modules.

---
 rtl/seq_stage_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - Y86-64 sequential-core stage sequencer with PC, stat and counters
// Optional SEQ_SINGLE_STEP_EN adds step/step_wait and a STEP_HOLD park state after each instruction.
module seq_stage_ctrl #(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       MAX_INSTR   = 0,
  parameter int unsigned       MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              dmem_error,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] next_pc,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
  output logic              step_wait,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        stage_en,
  output logic              mem_req,
  output logic [1:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT,
    S_STEP_HOLD
  } state_t;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [5:0] EN_FETCH = 6'b000001;
  localparam logic [5:0] EN_DEC   = 6'b000010;
  localparam logic [5:0] EN_EXE   = 6'b000100;
  localparam logic [5:0] EN_MEM   = 6'b001000;
  localparam logic [5:0] EN_WB    = 6'b010000;
  localparam logic [5:0] EN_PCUPD = 6'b100000;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_mem_op;
  logic              counting;
  logic              limit_hit;
  logic [CNT_W-1:0]  instr_inc;
  logic [CNT_W-1:0]  cycle_inc;

  // Only loads, stores, call/ret and push/pop touch data memory.
  always_comb begin
    is_mem_op = 1'b0;
    if (icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})
      is_mem_op = 1'b1;
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    counting  = (state inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD});
    instr_inc = (instr_count == '1) ? instr_count : instr_count + CNT_W'(1);
    cycle_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    limit_hit = (MAX_INSTR != 0) && (instr_inc == CNT_W'(MAX_INSTR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      stage_en    <= '0;
      mem_req     <= 1'b0;
      stat        <= STAT_AOK;
      halted      <= 1'b0;
      instr_count <= '0;
      cycle_count <= '0;
      wait_cnt    <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      step_wait   <= 1'b0;
`endif
    end else begin
      if (counting)
        cycle_count <= cycle_inc;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            stage_en <= EN_FETCH;
          end
        end

        S_FETCH: begin
          if (imem_error || !instr_valid) begin
            stat     <= imem_error ? STAT_ADR : STAT_INS;
            state    <= S_HALT;
            stage_en <= '0;
            halted   <= 1'b1;
          end else begin
            state    <= S_DECODE;
            stage_en <= EN_DEC;
          end
        end

        S_DECODE: begin
          state    <= S_EXECUTE;
          stage_en <= EN_EXE;
        end

        S_EXECUTE: begin
          state    <= S_MEMORY;
          stage_en <= EN_MEM;
          mem_req  <= is_mem_op;
          wait_cnt <= '0;
        end

        S_MEMORY: begin
          if (!mem_req) begin
            state    <= S_WRITEBACK;
            stage_en <= EN_WB;
          end else if (mem_ready) begin
            // An error reported with the completion overrides the completion.
            mem_req <= 1'b0;
            if (dmem_error) begin
              stat     <= STAT_ADR;
              state    <= S_HALT;
              stage_en <= '0;
              halted   <= 1'b1;
            end else begin
              state    <= S_WRITEBACK;
              stage_en <= EN_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            mem_req  <= 1'b0;
            stat     <= STAT_ADR;
            state    <= S_HALT;
            stage_en <= '0;
            halted   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WRITEBACK: begin
          state    <= S_PCUPD;
          stage_en <= EN_PCUPD;
        end

        S_PCUPD: begin
          pc          <= next_pc;
          instr_count <= instr_inc;
          if (icode == 4'h0 || limit_hit) begin
            // A halt instruction still commits its PC, as Y86 does.
            if (icode == 4'h0)
              stat <= STAT_HLT;
            state    <= S_HALT;
            stage_en <= '0;
            halted   <= 1'b1;
          end else begin
`ifdef SEQ_SINGLE_STEP_EN
            state     <= S_STEP_HOLD;
            stage_en  <= '0;
            step_wait <= 1'b1;
`else
            state    <= S_FETCH;
            stage_en <= EN_FETCH;
`endif
          end
        end

        S_HALT: begin
          stage_en <= '0;
          halted   <= 1'b1;
        end

`ifdef SEQ_SINGLE_STEP_EN
        S_STEP_HOLD: begin
          if (step) begin
            state     <= S_FETCH;
            stage_en  <= EN_FETCH;
            step_wait <= 1'b0;
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          stage_en <= '0;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb/tb_seq_stage_ctrl.sv - randomized self-checking bench for seq_stage_ctrl against a stage-schedule model
module tb_seq_stage_ctrl;

  localparam logic [63:0] RPC = 64'h100;
  localparam int TO_A  = 4;
  localparam int MAX_B = 2;
  localparam int CNTB  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        dmem_error = 1'b0;
  logic        mem_ready = 1'b0;
  logic [63:0] next_pc = '0;

  logic [63:0] pc;
  logic [5:0]  stage_en;
  logic        mem_req;
  logic [1:0]  stat;
  logic        halted;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;

  logic [63:0]     b_pc;
  logic [5:0]      b_stage_en;
  logic            b_mem_req;
  logic [1:0]      b_stat;
  logic            b_halted;
  logic [CNTB-1:0] b_instr_count;
  logic [CNTB-1:0] b_cycle_count;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] m_pc;
  logic [63:0] m_icnt;
  logic [63:0] m_ccnt;

  always #5 clk = ~clk;

  seq_stage_ctrl #(.ADDR_W(64), .RESET_PC(RPC), .CNT_W(32), .MAX_INSTR(0), .MEM_TIMEOUT(TO_A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .mem_ready(mem_ready), .next_pc(next_pc),
    .pc(pc), .stage_en(stage_en), .mem_req(mem_req), .stat(stat), .halted(halted),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  seq_stage_ctrl #(.ADDR_W(64), .RESET_PC(RPC), .CNT_W(CNTB), .MAX_INSTR(MAX_B), .MEM_TIMEOUT(TO_A)) dut_lim (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .mem_ready(mem_ready), .next_pc(next_pc),
    .pc(b_pc), .stage_en(b_stage_en), .mem_req(b_mem_req), .stat(b_stat), .halted(b_halted),
    .instr_count(b_instr_count), .cycle_count(b_cycle_count)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    m_pc = RPC; m_icnt = 0; m_ccnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals();
    check_val("rst_pc", pc, RPC);
    check_val("rst_en", stage_en, 0);
    check_val("rst_req", mem_req, 0);
    check_val("rst_stat", stat, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_icnt", instr_count, 0);
    check_val("rst_ccnt", cycle_count, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic halt_check(input logic [1:0] st);
    @(negedge clk);
    mem_ready = 1'b0; dmem_error = 1'b0; instr_valid = 1'b1; imem_error = 1'b0;
    check_val("halt_en", stage_en, 0);
    check_val("halt_flag", halted, 1);
    check_val("halt_stat", stat, st);
    check_val("halt_pc", pc, m_pc);
    check_val("halt_icnt", instr_count, m_icnt);
    check_val("halt_ccnt", cycle_count, m_ccnt);
    check_val("halt_req", mem_req, 0);
  endtask

  // mode: 0 normal, 1 memory never ready, 2 dmem_error with ready, 3 illegal instr, 4 imem_error
  task automatic run_instr(input logic [3:0] ic, input int wait_cy, input logic [63:0] npc, input int mode);
    bit memop;
    int mem_cycles;
    memop = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    @(negedge clk);
    check_val("fetch_en", stage_en, 6'b1 << 0);
    check_val("pc", pc, m_pc);
    check_val("icnt", instr_count, m_icnt);
    check_val("ccnt", cycle_count, m_ccnt);
    icode = ic; next_pc = npc;
    instr_valid = (mode < 3);
    imem_error = (mode == 4);
    m_ccnt++;
    if (mode >= 3) begin
      halt_check((mode == 4) ? 2'd2 : 2'd3);
    end else begin
      for (int s = 1; s <= 2; s++) begin
        @(negedge clk);
        check_val("dec_exe_en", stage_en, 6'b1 << s);
        m_ccnt++;
      end
      mem_cycles = !memop ? 1 : (mode == 1) ? TO_A : wait_cy + 1;
      for (int j = 0; j < mem_cycles; j++) begin
        @(negedge clk);
        check_val("mem_en", stage_en, 6'b1 << 3);
        check_val("mem_req", mem_req, memop);
        mem_ready  = memop && (mode != 1) && (j == wait_cy);
        dmem_error = memop && (mode == 2) && (j == wait_cy);
        m_ccnt++;
      end
      if (memop && (mode == 1 || mode == 2)) begin
        halt_check(2'd2);
      end else begin
        @(negedge clk);
        mem_ready = 1'b0;
        check_val("wb_en", stage_en, 6'b1 << 4);
        check_val("wb_req", mem_req, 0);
        m_ccnt++;
        @(negedge clk);
        check_val("pcupd_en", stage_en, 6'b1 << 5);
        m_ccnt++;
        m_pc = npc;
        m_icnt++;
        if (ic == 4'h0)
          halt_check(2'd1);
      end
    end
  endtask

  initial begin
    logic [3:0]  ric;
    logic [63:0] rpc;
    logic [63:0] exp_bc;

    do_reset();
    #1 check_reset_vals();

    // nop, 3-wait load, then halt as the third instruction
    pulse_start();
    run_instr(4'h1, 0, 64'h101, 0);
    run_instr(4'h5, 3, 64'h10b, 0);
    run_instr(4'h0, 0, 64'h10d, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    check_val("ign_start_en", stage_en, 0);
    check_val("ign_start_halted", halted, 1);
    check_val("ign_start_pc", pc, m_pc);
    check_val("ign_start_ccnt", cycle_count, m_ccnt);

    do_reset();
    pulse_start();
    run_instr(4'h2, 0, 64'h4000, 0);
    run_instr(4'h6, 0, 64'h5000, 3);

    do_reset();
    pulse_start();
    run_instr(4'h6, 0, 64'h5000, 4);

    do_reset();
    pulse_start();
    run_instr(4'hA, 0, 64'h6000, 1);

    do_reset();
    pulse_start();
    run_instr(4'h4, $urandom_range(0, TO_A - 1), 64'h7000, 2);

    do_reset();
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      ric = 4'($urandom_range(1, 11));
      rpc = {$urandom, $urandom};
      run_instr(ric, $urandom_range(0, TO_A - 1), rpc, 0);
    end
    run_instr(4'h0, 0, {$urandom, $urandom}, 0);

    // retire limit on the second instance, then asynchronous reset mid-FETCH
    do_reset();
    pulse_start();
    run_instr(4'h1, 0, 64'h200, 0);
    run_instr(4'h1, 0, 64'h300, 0);
    @(negedge clk);
    exp_bc = (m_ccnt > 64'((1 << CNTB) - 1)) ? 64'((1 << CNTB) - 1) : m_ccnt;
    check_val("lim_halted", b_halted, m_icnt >= MAX_B);
    check_val("lim_stat", b_stat, 0);
    check_val("lim_icnt", b_instr_count, MAX_B);
    check_val("lim_ccnt_sat", b_cycle_count, exp_bc);
    check_val("lim_en", b_stage_en, 0);
    check_val("lim_pc", b_pc, m_pc);
    check_val("nolim_fetch_en", stage_en, 6'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    check_val("lim_rst_halted", b_halted, 0);
    check_val("lim_rst_icnt", b_instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
